// File: rtl/branch_resolve_unit.sv
// Branch resolution for the EX stage: operand compares, funct3 decode, registered
// resolution results, a 2-bit saturating branch-history table and saturating statistics.
module branch_resolve_unit #(
  parameter int XLEN      = 32,
  parameter int PC_W      = 32,
  parameter int BHT_DEPTH = 16,
  parameter int CNT_W     = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ex_valid,
  input  logic              i_ex_branch,
  input  logic [2:0]        i_ex_funct3,
  input  logic [XLEN-1:0]   i_rs1,
  input  logic [XLEN-1:0]   i_rs2,
  input  logic [PC_W-1:0]   i_ex_pc,
  input  logic              i_ex_pred_taken,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic [PC_W-1:0]   i_if_pc,
  output logic              o_if_pred_taken,
  output logic              o_br_eq,
  output logic              o_br_lt,
  output logic              o_br_ltu,
  output logic              o_res_valid,
  output logic              o_res_taken,
  output logic              o_res_mispredict,
  output logic              o_res_illegal,
  output logic [PC_W-1:0]   o_res_pc,
  output logic [CNT_W-1:0]  o_cnt_branches,
  output logic [CNT_W-1:0]  o_cnt_mispred
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic              w_eq;
  logic              w_lt;
  logic              w_ltu;
  logic              w_taken;
  logic              w_illegal;
  logic              w_mispredict;
  logic              w_resolve;
  logic              w_legal_resolve;
  logic [IDX_W-1:0]  w_ex_idx;
  logic [IDX_W-1:0]  w_if_idx;

  logic              r_res_valid;
  logic              r_res_taken;
  logic              r_res_mispredict;
  logic              r_res_illegal;
  logic [PC_W-1:0]   r_res_pc;
  logic [CNT_W-1:0]  r_cnt_branches;
  logic [CNT_W-1:0]  r_cnt_mispred;
  logic [1:0]        r_bht [BHT_DEPTH];

  function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  function automatic logic [1:0] f_bht_step(input logic [1:0] c, input logic t);
    if (t) begin
      return (c == 2'b11) ? 2'b11 : c + 2'b01;
    end else begin
      return (c == 2'b00) ? 2'b00 : c - 2'b01;
    end
  endfunction

  assign w_eq  = (i_rs1 == i_rs2);
  assign w_lt  = ($signed(i_rs1) < $signed(i_rs2));
  assign w_ltu = (i_rs1 < i_rs2);

  assign o_br_eq  = w_eq;
  assign o_br_lt  = w_lt;
  assign o_br_ltu = w_ltu;

  // funct3 to branch direction; the two reserved encodings flag illegal
  always_comb begin
    w_taken   = 1'b0;
    w_illegal = 1'b0;
    case (i_ex_funct3)
      3'b000:  w_taken = w_eq;
      3'b001:  w_taken = ~w_eq;
      3'b100:  w_taken = w_lt;
      3'b101:  w_taken = ~w_lt;
      3'b110:  w_taken = w_ltu;
      3'b111:  w_taken = ~w_ltu;
      default: begin
        w_taken   = 1'b0;
        w_illegal = 1'b1;
      end
    endcase
  end

  assign w_mispredict    = ~w_illegal & (w_taken ^ i_ex_pred_taken);
  assign w_resolve       = i_ex_valid & i_ex_branch & ~i_stall & ~i_flush;
  assign w_legal_resolve = w_resolve & ~w_illegal;

  assign w_ex_idx = i_ex_pc[IDX_W+1:2];
  assign w_if_idx = i_if_pc[IDX_W+1:2];

  // Lookup reads the stored entry, so a same-cycle update is seen only next cycle
  assign o_if_pred_taken = r_bht[w_if_idx][1];

  // Resolution result registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_res_valid      <= 1'b0;
      r_res_taken      <= 1'b0;
      r_res_mispredict <= 1'b0;
      r_res_illegal    <= 1'b0;
      r_res_pc         <= {PC_W{1'b0}};
    end else if (i_flush) begin
      r_res_valid      <= 1'b0;
      r_res_mispredict <= 1'b0;
      r_res_illegal    <= 1'b0;
    end else if (i_stall) begin
      r_res_valid      <= r_res_valid;
    end else if (w_resolve) begin
      r_res_valid      <= 1'b1;
      r_res_taken      <= w_taken;
      r_res_mispredict <= w_mispredict;
      r_res_illegal    <= w_illegal;
      r_res_pc         <= i_ex_pc;
    end else begin
      r_res_valid      <= 1'b0;
      r_res_mispredict <= 1'b0;
      r_res_illegal    <= 1'b0;
    end
  end

  // Branch-history table, reset to weakly not-taken
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        r_bht[i] <= 2'b01;
      end
    end else if (w_legal_resolve) begin
      r_bht[w_ex_idx] <= f_bht_step(r_bht[w_ex_idx], w_taken);
    end else begin
      r_bht[w_ex_idx] <= r_bht[w_ex_idx];
    end
  end

  // Saturating statistics counters
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt_branches <= {CNT_W{1'b0}};
      r_cnt_mispred  <= {CNT_W{1'b0}};
    end else if (w_legal_resolve) begin
      r_cnt_branches <= f_sat_inc(r_cnt_branches);
      r_cnt_mispred  <= w_mispredict ? f_sat_inc(r_cnt_mispred) : r_cnt_mispred;
    end else begin
      r_cnt_branches <= r_cnt_branches;
      r_cnt_mispred  <= r_cnt_mispred;
    end
  end

  assign o_res_valid      = r_res_valid;
  assign o_res_taken      = r_res_taken;
  assign o_res_mispredict = r_res_mispredict;
  assign o_res_illegal    = r_res_illegal;
  assign o_res_pc         = r_res_pc;
  assign o_cnt_branches   = r_cnt_branches;
  assign o_cnt_mispred    = r_cnt_mispred;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: a default instance and a CNT_W=4 instance share
// stimulus; a behavioural model is compared every cycle, plus hand-computed literal checks.
module tb_branch_resolve_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ex_valid, ex_branch, ex_pred, stall, flush;
  logic [2:0]  f3;
  logic [31:0] rs1, rs2, ex_pc, if_pc;

  logic        pred, eq, lt, ltu, rv, rt, rm, ri;
  logic [31:0] rpc;
  logic [15:0] cb, cm;
  logic        pred4, eq4, lt4, ltu4, rv4, rt4, rm4, ri4;
  logic [31:0] rpc4;
  logic [3:0]  cb4, cm4;

  branch_resolve_unit dut (
    .i_clk(clk), .i_rst(rst), .i_ex_valid(ex_valid), .i_ex_branch(ex_branch),
    .i_ex_funct3(f3), .i_rs1(rs1), .i_rs2(rs2), .i_ex_pc(ex_pc),
    .i_ex_pred_taken(ex_pred), .i_stall(stall), .i_flush(flush), .i_if_pc(if_pc),
    .o_if_pred_taken(pred), .o_br_eq(eq), .o_br_lt(lt), .o_br_ltu(ltu),
    .o_res_valid(rv), .o_res_taken(rt), .o_res_mispredict(rm), .o_res_illegal(ri),
    .o_res_pc(rpc), .o_cnt_branches(cb), .o_cnt_mispred(cm)
  );

  branch_resolve_unit #(.CNT_W(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_ex_valid(ex_valid), .i_ex_branch(ex_branch),
    .i_ex_funct3(f3), .i_rs1(rs1), .i_rs2(rs2), .i_ex_pc(ex_pc),
    .i_ex_pred_taken(ex_pred), .i_stall(stall), .i_flush(flush), .i_if_pc(if_pc),
    .o_if_pred_taken(pred4), .o_br_eq(eq4), .o_br_lt(lt4), .o_br_ltu(ltu4),
    .o_res_valid(rv4), .o_res_taken(rt4), .o_res_mispredict(rm4), .o_res_illegal(ri4),
    .o_res_pc(rpc4), .o_cnt_branches(cb4), .o_cnt_mispred(cm4)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit m_illegal(input logic [2:0] f);
    return f[2:1] == 2'b01;
  endfunction

  function automatic bit m_taken(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    bit c;
    case (f[2:1])
      2'b00:   c = (a == b);
      2'b10:   c = ($signed(a) < $signed(b));
      2'b11:   c = (a < b);
      default: c = 1'b0;
    endcase
    return m_illegal(f) ? 1'b0 : (c ^ f[0]);
  endfunction

  int          m_bht [16];
  bit          m_valid, m_tk, m_mis, m_ill;
  logic [31:0] m_pc;
  int          m_cb, m_cm, m_cb4, m_cm4;

  always @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0; m_tk <= 1'b0; m_mis <= 1'b0; m_ill <= 1'b0; m_pc <= 32'h0;
      m_cb <= 0; m_cm <= 0; m_cb4 <= 0; m_cm4 <= 0;
      for (int i = 0; i < 16; i++) m_bht[i] <= 1;
    end else if (flush) begin
      m_valid <= 1'b0; m_mis <= 1'b0; m_ill <= 1'b0;
    end else if (stall) begin
      m_valid <= m_valid;
    end else if (ex_valid && ex_branch) begin
      m_valid <= 1'b1;
      m_tk    <= m_taken(f3, rs1, rs2);
      m_ill   <= m_illegal(f3);
      m_mis   <= !m_illegal(f3) && (m_taken(f3, rs1, rs2) != ex_pred);
      m_pc    <= ex_pc;
      if (!m_illegal(f3)) begin
        if (m_taken(f3, rs1, rs2))
          m_bht[ex_pc[5:2]] <= (m_bht[ex_pc[5:2]] == 3) ? 3 : m_bht[ex_pc[5:2]] + 1;
        else
          m_bht[ex_pc[5:2]] <= (m_bht[ex_pc[5:2]] == 0) ? 0 : m_bht[ex_pc[5:2]] - 1;
        m_cb  <= (m_cb  == 65535) ? m_cb  : m_cb  + 1;
        m_cb4 <= (m_cb4 == 15)    ? m_cb4 : m_cb4 + 1;
        if (m_taken(f3, rs1, rs2) != ex_pred) begin
          m_cm  <= (m_cm  == 65535) ? m_cm  : m_cm  + 1;
          m_cm4 <= (m_cm4 == 15)    ? m_cm4 : m_cm4 + 1;
        end
      end
    end else begin
      m_valid <= 1'b0; m_mis <= 1'b0; m_ill <= 1'b0;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("eq",        eq,   rs1 == rs2);
      chk("lt",        lt,   $signed(rs1) < $signed(rs2));
      chk("ltu",       ltu,  rs1 < rs2);
      chk("if_pred",   pred, m_bht[if_pc[5:2]] >= 2);
      chk("res_valid", rv,   m_valid);
      chk("res_taken", rt,   m_tk);
      chk("res_mis",   rm,   m_mis);
      chk("res_ill",   ri,   m_ill);
      chk("res_pc",    rpc,  m_pc);
      chk("cnt_br",    cb,   m_cb);
      chk("cnt_mis",   cm,   m_cm);
      chk("if_pred4",  pred4, m_bht[if_pc[5:2]] >= 2);
      chk("res_valid4", rv4, m_valid);
      chk("res_mis4",  rm4,  m_mis);
      chk("res_pc4",   rpc4, m_pc);
      chk("cnt_br4",   cb4,  m_cb4);
      chk("cnt_mis4",  cm4,  m_cm4);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic br(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] pc, input logic p);
    ex_valid = 1'b1; ex_branch = 1'b1; f3 = f; rs1 = a; rs2 = b; ex_pc = pc; ex_pred = p;
  endtask

  task automatic idle;
    ex_valid = 1'b0;
  endtask

  logic [31:0] op_a [4] = '{32'h5, 32'h3, 32'hFFFF_FFF0, 32'h2};
  logic [31:0] op_b [4] = '{32'h5, 32'h7, 32'h2, 32'hFFFF_FFF0};
  logic [31:0] pcs  [3] = '{32'h0, 32'h44, 32'h3C};

  initial begin
    rst = 1'b1; ex_valid = 1'b0; ex_branch = 1'b0; ex_pred = 1'b0; stall = 1'b0;
    flush = 1'b0; f3 = 3'b000; rs1 = 32'h0; rs2 = 32'h0; ex_pc = 32'h0; if_pc = 32'h0;
    tick; tick;
    chk_en = 1'b1;

    // reset state
    chk("rst_valid", rv, 1'b0);
    chk("rst_cnt_br", cb, 16'h0);
    foreach (pcs[i]) begin
      if_pc = pcs[i]; #1;
      chk("rst_pred", pred, 1'b0);
    end
    rst = 1'b0;

    // signed vs unsigned compare, mispredicted BLT
    br(3'b100, 32'hFFFF_FFFF, 32'h1, 32'h104, 1'b0); #1;
    chk("s1_lt", lt, 1'b1);
    chk("s1_ltu", ltu, 1'b0);
    tick; idle;
    chk("s1_valid", rv, 1'b1);
    chk("s1_taken", rt, 1'b1);
    chk("s1_mis", rm, 1'b1);
    chk("s1_cnt_mis", cm, 16'h1);
    chk("s1_pc", rpc, 32'h104);
    tick;
    chk("idle_valid", rv, 1'b0);
    chk("idle_taken_hold", rt, 1'b1);
    chk("idle_pc_hold", rpc, 32'h104);

    // three taken BEQ at 0x40 walk the entry up to saturation
    if_pc = 32'h40;
    br(3'b000, 32'h5, 32'h5, 32'h40, 1'b1); #1;
    chk("bht_read0", pred, 1'b0);
    tick;
    chk("bht_read1", pred, 1'b1);
    tick;
    chk("bht_read2", pred, 1'b1);
    tick; idle;
    chk("bht_sat", pred, 1'b1);
    chk("bht_cnt_br", cb, 16'h4);
    // not-taken BNE walks it back down: 11->10->01->00->00
    br(3'b001, 32'h5, 32'h5, 32'h40, 1'b1);
    tick;
    chk("bht_dn1", pred, 1'b1);
    tick;
    chk("bht_dn2", pred, 1'b0);
    tick; tick; idle;
    chk("bht_dn_floor", pred, 1'b0);
    chk("dn_cnt_br", cb, 16'h8);
    chk("dn_cnt_mis", cm, 16'h5);

    // stall holds everything, flush beats stall
    br(3'b000, 32'h7, 32'h7, 32'h48, 1'b0);
    tick;
    stall = 1'b1; ex_pc = 32'h4C;
    repeat (3) begin
      tick;
      chk("stall_valid", rv, 1'b1);
      chk("stall_pc", rpc, 32'h48);
      chk("stall_cnt_br", cb, 16'h9);
      chk("stall_cnt_mis", cm, 16'h6);
    end
    flush = 1'b1;
    tick;
    chk("flush_valid", rv, 1'b0);
    chk("flush_cnt_br", cb, 16'h9);
    flush = 1'b0; stall = 1'b0; idle;

    // reserved funct3
    br(3'b010, 32'h1, 32'h2, 32'h48, 1'b1);
    tick; idle;
    chk("ill_flag", ri, 1'b1);
    chk("ill_taken", rt, 1'b0);
    chk("ill_mis", rm, 1'b0);
    chk("ill_cnt_br", cb, 16'h9);
    if_pc = 32'h48; #1;
    chk("ill_bht", pred, 1'b1);
    tick;

    // decode sweep over all funct3 values and operand shapes
    for (int f = 0; f < 8; f++) begin
      for (int k = 0; k < 4; k++) begin
        br(3'(f), op_a[k], op_b[k], 32'h200 + 32'(4 * k), 1'(k));
        tick;
      end
    end
    idle; tick;

    // counter saturation on the narrow instance
    repeat (17) begin
      br(3'b000, 32'h9, 32'h9, 32'h60, 1'b0);
      tick;
    end
    idle; tick;
    chk("sat_cnt_br4", cb4, 4'hF);
    chk("sat_cnt_mis4", cm4, 4'hF);

    // reset overrides a presented resolve, stall and flush
    br(3'b000, 32'h1, 32'h1, 32'h40, 1'b0);
    rst = 1'b1; stall = 1'b1; flush = 1'b1;
    tick;
    rst = 1'b0; stall = 1'b0; flush = 1'b0; idle;
    chk("rst2_valid", rv, 1'b0);
    chk("rst2_taken", rt, 1'b0);
    chk("rst2_pc", rpc, 32'h0);
    chk("rst2_cnt_br", cb, 16'h0);
    chk("rst2_cnt_mis4", cm4, 4'h0);
    if_pc = 32'h40; #1; chk("rst2_pred40", pred, 1'b0);
    if_pc = 32'h48; #1; chk("rst2_pred48", pred, 1'b0);
    if_pc = 32'h60; #1; chk("rst2_pred60", pred, 1'b0);
    tick; tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
